// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU datapath width and the NOT operation helper.
package alu_pkg;
    localparam int ALU_WIDTH = 32;

    function automatic logic [ALU_WIDTH-1:0] alu_not(input logic [ALU_WIDTH-1:0] a);
        return ~a;
    endfunction
endpackage

// File: rtl/not_skid_buf.sv
// not_skid_buf: 2-entry valid/ready skid buffer with a registered in_ready.
module not_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire, drain;

    always_comb begin
        in_fire      = in_valid & ~skid_valid_q;
        // the output register can take a new item when empty or being consumed this edge
        drain        = ~out_valid_q | out_ready;
        out_valid_d  = drain ? (skid_valid_q | in_fire) : out_valid_q;
        out_data_d   = drain ? (skid_valid_q ? skid_data_q : (in_fire ? in_data : out_data_q)) : out_data_q;
        skid_valid_d = drain ? 1'b0 : (skid_valid_q | in_fire);
        skid_data_d  = (~drain & in_fire) ? in_data : skid_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule

// File: rtl/bitwise_not_unit.sv
// bitwise_not_unit: streaming bitwise inverter; complements operands ahead of a skid buffer.
module bitwise_not_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic [WIDTH-1:0] not_a;

    assign not_a = ~in_a;

    not_skid_buf #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (not_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );
endmodule

// File: tb/tb_bitwise_not_unit.sv
// tb_bitwise_not_unit: directed and scoreboarded checks of the streaming inverter.
module tb_bitwise_not_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    int          checks = 0;
    int          failures = 0;

    bitwise_not_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'd5;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++;
        if (out_data !== 32'hFFFFFFFA) begin failures++; $display("FAIL single_data got=%h exp=fffffffa", out_data); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drop got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 32'hFFFFFFFA) begin failures++; $display("FAIL single_hold got=%h exp=fffffffa", out_data); end
    endtask

    task automatic test_patterns();
        logic [31:0] vin [3]  = '{32'h00000000, 32'hFFFFFFFF, 32'hA5A5A5A5};
        logic [31:0] vexp [3] = '{32'hFFFFFFFF, 32'h00000000, 32'h5A5A5A5A};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = vin[i];
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== vexp[i]) begin
                failures++;
                $display("FAIL pattern_%0d got=%b/%h exp=1/%h", i, out_valid, out_data, vexp[i]);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_a     = i;
            step();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== ~i) begin
                failures++;
                $display("FAIL b2b_%0d got=rdy%b v%b %h exp=rdy1 v1 %h", i, in_ready, out_valid, out_data, ~i);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'd1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_data !== 32'hFFFFFFFE) begin failures++; $display("FAIL bp_first got=rdy%b %h exp=rdy1 fffffffe", in_ready, out_data); end
        in_a = 32'd2;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hFFFFFFFE) begin failures++; $display("FAIL bp_full got=rdy%b v%b %h exp=rdy0 v1 fffffffe", in_ready, out_valid, out_data); end
        in_a = 32'd3;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 32'hFFFFFFFE) begin failures++; $display("FAIL bp_hold got=rdy%b %h exp=rdy0 fffffffe", in_ready, out_data); end
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hFFFFFFFD) begin failures++; $display("FAIL bp_drain1 got=rdy%b v%b %h exp=rdy1 v1 fffffffd", in_ready, out_valid, out_data); end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFC) begin failures++; $display("FAIL bp_drain2 got=v%b %h exp=v1 fffffffc", out_valid, out_data); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'd7;
        step();
        in_a = 32'd8;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL rm_full got=rdy%b v%b exp=rdy0 v1", in_ready, out_valid); end
        rst       = 1'b1;
        out_ready = 1'b1;
        in_a      = 32'd9;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rm_after got=v%b %h rdy%b exp=v0 00000000 rdy1", out_valid, out_data, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_stale_%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_random();
        logic [31:0] q [$];
        logic [31:0] exp_d;
        int n_in = 0;
        int n_out = 0;
        bit m_rdy;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_a      = $urandom;
            m_rdy     = q.size() < 2;
            checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== m_rdy) begin
                failures++;
                $display("FAIL rnd_flags c=%0d got=v%b rdy%b exp=v%b rdy%b", c, out_valid, in_ready, q.size() != 0, m_rdy);
            end
            if (q.size() != 0 && out_ready) begin
                exp_d = q.pop_front();
                n_out++;
                checks++;
                if (out_data !== exp_d) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_data, exp_d); end
            end
            if (in_valid && m_rdy) begin
                q.push_back(~in_a);
                n_in++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4 && q.size() != 0; c++) begin
            exp_d = q.pop_front();
            n_out++;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d) begin failures++; $display("FAIL rnd_drain got=v%b %h exp=v1 %h", out_valid, out_data, exp_d); end
            step();
        end
        checks++;
        if (n_in != n_out || out_valid !== 1'b0) begin failures++; $display("FAIL rnd_count got=in%0d out%0d v%b exp=equal v0", n_in, n_out, out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_patterns();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bitwise_not_unit.md
Name: bitwise_not_unit

Overview:
Streaming 32-bit bitwise inverter, the NOT operation slice of the ALU datapath. It accepts one operand per cycle over a valid/ready handshake and returns the bitwise complement (~A) on a registered, backpressure-safe output. It sits between the ALU operand mux and the result collector.

Parameters:
WIDTH, 32, operand and result width in bits (must be >= 1).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
in_valid  input  1  operand A present on in_a.
in_ready  output  1  unit can accept an operand this cycle.
in_a  input  WIDTH  operand A, unsigned.
out_valid  output  1  result present on out_data.
out_ready  input  1  downstream accepts the result this cycle.
out_data  output  WIDTH  result, ~A.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready on a rising edge.
  - Output transfer occurs when out_valid && out_ready on a rising edge.
- Function: out_data = bitwise complement of the accepted in_a, all WIDTH bits, no sign or width extension.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N; 1-cycle latency when the output stage is empty or draining.
- Storage is 2 entries: an output register plus one skid register.
  - in_ready is a registered signal, equal to "skid register empty". It never depends combinationally on out_ready.
  - Throughput is 1 result per cycle while out_ready=1.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - An operand accepted during a stall goes to the skid register, and in_ready drops on the next cycle.
  - When the output drains, skid contents move to the output register in the same edge, and in_ready returns to 1 on the next cycle.
- Simultaneous input and output transfer in one cycle: the output register loads the next item (skid entry first if present, else the new operand). There is no bubble, no loss, and no duplication.
- Ordering: results are emitted strictly in acceptance order.
- Reset: when rst=1 at a rising edge:
  - out_valid=0, out_data=0, skid register empty, in_ready=1.
  - Any in-flight items are discarded.
  - Handshakes presented in the same cycle as rst are ignored.
- in_a is not used when in_valid=0. out_data is don't-care when out_valid=0, but it must hold its last value (0 after reset).
- No X propagation from in_a into state unless a transfer occurs.

Decomposition:
- Shared package alu_pkg: localparam ALU_WIDTH=32, used as the WIDTH default.
- One natural sub-module: not_skid_buf, a generic 2-entry valid/ready skid buffer parameterised by WIDTH. The top level instantiates it and applies the inversion on the input side, before the data is registered.

Test Plan:
- Reset, then in_a=5 with in_valid=1 for one cycle and out_ready=1 -> one cycle later out_valid=1, out_data=32'hFFFFFFFA (4294967290); the next cycle out_valid=0.
- in_a=0 -> out_data=32'hFFFFFFFF; in_a=32'hFFFFFFFF -> out_data=0; in_a=32'hA5A5A5A5 -> out_data=32'h5A5A5A5A.
- Back-to-back stream 0..15, in_valid=1 every cycle, out_ready=1 -> in_ready stays 1, 16 results ~0..~15 on consecutive cycles, in order.
- Backpressure: out_ready=0 while sending 1, 2, 3 -> in_ready=0 after two acceptances, out_data holds 32'hFFFFFFFE. Then out_ready=1 -> outputs FFFFFFFE, FFFFFFFD, FFFFFFFC in order with no loss.
- Reset mid-operation: with both entries full, assert rst for one cycle -> out_valid=0, out_data=0, in_ready=1 next cycle; no stale result is ever emitted afterwards.
- Random stimulus: random in_valid/out_ready over 10k cycles against a scoreboard queue -> every output equals ~input, in order, and the count in equals the count out.
